dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the data memory / MMIO block. Port 0 is the CPU load/store path and port 1 is the loader/debug path. The block grants the single memory port round-robin and drives the memory's `Address`, `Datawr`, `MemWr` and `MemRd` inputs from registers. It captures read data and returns a one-cycle acknowledge to the winning requester. It sits between the datapath and the data memory; the CPU stalls on `req0 & ~ack0`.

---
 rtl/dmem_arbiter_if.sv | 28 ++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// master = requester/memory side, slave = arbiter side.
interface dmem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic          req0, req1;
    logic          we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1;
    logic          err0, err1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wr, mem_rd;
    logic [DW-1:0] mem_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, err0, err1, rdata, mem_addr, mem_wdata, mem_wr, mem_rd
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, err0, err1, rdata, mem_addr, mem_wdata, mem_wr, mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer for the data memory: IDLE -> SERVE -> DONE.
// Optional address rejection is enabled with `define DMEM_ARB_ERR_CHECK_EN.
module dmem_arbiter #(
    parameter int MEM_BYTES = 400,
    parameter int AW        = 64,
    parameter int DW        = 64
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SERVE, DONE} state_t;

    state_t        state, state_nx;
    logic          last_gnt, gnt, we_q, rej_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q;

    logic          win0, win1, win_we, win_rej;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // On a tie the port that did not win last time gets the grant.
    assign win0      = bus.req0 & (~bus.req1 | last_gnt);
    assign win1      = bus.req1 & (~bus.req0 | ~last_gnt);
    assign win_addr  = win1 ? bus.addr1  : bus.addr0;
    assign win_wdata = win1 ? bus.wdata1 : bus.wdata0;
    assign win_we    = win1 ? bus.we1    : bus.we0;

`ifdef DMEM_ARB_ERR_CHECK_EN
    localparam logic [AW:0] LAST_BYTE = (AW+1)'(MEM_BYTES - 1);
    logic [AW:0] win_end;
    // One extra bit keeps the end-of-word sum from wrapping.
    assign win_end = {1'b0, win_addr} + (AW+1)'(7);
    assign win_rej = (win_addr[17:16] == 2'd3) |
                     ((win_addr[17:16] == 2'd0) & (win_end > LAST_BYTE));
`else
    logic unused_cfg;
    assign unused_cfg = (MEM_BYTES == 0);
    assign win_rej    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = (win0 | win1) ? SERVE : IDLE;
            SERVE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
            gnt      <= 1'b0;
            we_q     <= 1'b0;
            rej_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (state == IDLE && (win0 | win1)) begin
                last_gnt <= win1;
                gnt      <= win1;
                we_q     <= win_we;
                rej_q    <= win_rej;
                addr_q   <= win_addr;
                wdata_q  <= win_wdata;
            end
            // Stores leave rdata alone; rejected accesses report zero.
            if (state == SERVE) begin
                if (rej_q)      rdata_q <= '0;
                else if (!we_q) rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        bus.mem_wr = 1'b0;
        bus.mem_rd = 1'b0;
        bus.ack0   = 1'b0;
        bus.ack1   = 1'b0;
        bus.err0   = 1'b0;
        bus.err1   = 1'b0;
        case (state)
            SERVE: begin
                bus.mem_wr = we_q & ~rej_q;
                bus.mem_rd = ~we_q & ~rej_q;
            end
            DONE: begin
                bus.ack0 = ~gnt;
                bus.ack1 = gnt;
                bus.err0 = ~gnt & rej_q;
                bus.err1 = gnt & rej_q;
            end
            default: ;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then random two-port traffic.
module tb_dmem_arbiter;
    localparam int AW = 64, DW = 64, MEM_BYTES = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW), .DW(DW)) bus();
    dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        bit          we;
        logic [63:0] addr;
        logic [63:0] data;
        bit          err;
        int          lo;
        int          hi;
    } item_t;

    item_t       q0[$], q1[$];
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] mem [0:2047];
    int checks = 0, errors = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int midx(logic [63:0] a);
        return int'({21'b0, a[17:16], a[8:0]});
    endfunction

    // Environment memory: write commits on the edge ending SERVE.
    always @(posedge clk) if (!rst && bus.mem_wr) mem[midx(bus.mem_addr)] <= bus.mem_wdata;
    always @(negedge clk) bus.mem_rdata = mem[midx(bus.mem_addr)];

    function automatic bit exp_err(logic [63:0] a);
`ifdef DMEM_ARB_ERR_CHECK_EN
        return (a[17:16] == 2'd3) ||
               (a[17:16] == 2'd0 && (a + 64'd7) > 64'(MEM_BYTES - 1));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [63:0] ref_rd(logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 64'd0;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_ack0"}, 64'(bus.ack0), 0);
        check({tag, "_ack1"}, 64'(bus.ack1), 0);
        check({tag, "_err0"}, 64'(bus.err0), 0);
        check({tag, "_err1"}, 64'(bus.err1), 0);
        check({tag, "_rdata"}, bus.rdata, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_mem_wr"}, 64'(bus.mem_wr), 0);
        check({tag, "_mem_rd"}, 64'(bus.mem_rd), 0);
    endtask

    task automatic set_req(int p, bit v);
        if (p == 0) bus.req0 = v; else bus.req1 = v;
    endtask

    // Issue one transaction; ack must land lo..hi cycles after issue.
    task automatic txn(int p, bit we, logic [63:0] a, logic [63:0] d, int lo, int hi, bit drop = 0);
        item_t it;
        int n;
        it.we   = we;
        it.addr = a;
        it.err  = exp_err(a);
        it.lo   = cyc + lo;
        it.hi   = cyc + hi;
        it.data = we ? d : ref_rd(a);
        if (we && !it.err) ref_mem[a] = d;
        if (p == 0) begin
            q0.push_back(it);
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            q1.push_back(it);
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
        if (drop) begin
            @(posedge clk); #1;
            if (p == 0) begin
                bus.req0 = 1'b0; bus.we0 = ~we; bus.addr0 = {$urandom, $urandom}; bus.wdata0 = {$urandom, $urandom};
            end else begin
                bus.req1 = 1'b0; bus.we1 = ~we; bus.addr1 = {$urandom, $urandom}; bus.wdata1 = {$urandom, $urandom};
            end
        end
        n = 0;
        forever begin
            @(negedge clk);
            if ((p == 0) ? bus.ack0 : bus.ack1) break;
            n++;
            if (n > 20) begin
                checks++; errors++;
                $display("FAIL ack%0d_timeout: no ack within %0d cycles, required one", p, n);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic rand_port(int p, int count);
        for (int i = 0; i < count; i++) begin
            int gap, k;
            logic [63:0] a;
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                set_req(p, 1'b0);
                repeat (gap) @(posedge clk);
                #1;
            end
            if (p == 0) begin
                k = $urandom_range(0, 23);
                a = (k < 20) ? 64'(8 * k) : 64'h30000 + 64'(8 * (k - 20));
            end else begin
                a = 64'(8 * ($urandom_range(0, 19) + 25));
            end
            txn(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 2, 6);
        end
        set_req(p, 1'b0);
    endtask

    // Monitor: pops the expected item on every ack and checks the preceding SERVE cycle.
    initial begin
        logic        prev_wr, prev_rd;
        logic [63:0] prev_addr, prev_wdata, exp_rdata;
        item_t       it;
        prev_wr = 0; prev_rd = 0; prev_addr = 0; prev_wdata = 0; exp_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_wr = 0; prev_rd = 0; exp_rdata = 0;
            end else begin
                check("ack_exclusive", 64'(bus.ack0 & bus.ack1), 0);
                check("strobe_exclusive", 64'(bus.mem_wr & bus.mem_rd), 0);
                check("strobe_one_cycle", 64'((bus.mem_wr | bus.mem_rd) & (prev_wr | prev_rd)), 0);
                check("err_without_ack", 64'((bus.err0 & ~bus.ack0) | (bus.err1 & ~bus.ack1)), 0);
                for (int p = 0; p < 2; p++) begin
                    if ((p == 0) ? bus.ack0 : bus.ack1) begin
                        if ((p == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                            checks++; errors++;
                            $display("FAIL ack%0d_unexpected: ack seen at cycle %0d, none outstanding", p, cyc);
                        end else begin
                            it = (p == 0) ? q0.pop_front() : q1.pop_front();
                            checks++;
                            if (cyc < it.lo || cyc > it.hi) begin
                                errors++;
                                $display("FAIL ack%0d_latency: ack at cycle %0d, required %0d..%0d", p, cyc, it.lo, it.hi);
                            end
                            check($sformatf("err%0d", p), 64'((p == 0) ? bus.err0 : bus.err1), 64'(it.err));
                            if (it.err)      exp_rdata = 0;
                            else if (!it.we) exp_rdata = it.data;
                            check($sformatf("rdata%0d", p), bus.rdata, exp_rdata);
                            check($sformatf("mem_wr%0d", p), 64'(prev_wr), 64'(it.we && !it.err));
                            check($sformatf("mem_rd%0d", p), 64'(prev_rd), 64'(!it.we && !it.err));
                            check($sformatf("mem_addr%0d", p), prev_addr, it.addr);
                            if (it.we) check($sformatf("mem_wdata%0d", p), prev_wdata, it.data);
                        end
                    end
                end
                prev_wr = bus.mem_wr; prev_rd = bus.mem_rd;
                prev_addr = bus.mem_addr; prev_wdata = bus.mem_wdata;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 64'd0;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus.mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 0;
        @(posedge clk); #1;

        // Port 0 store, then port 1 reads it back.
        txn(0, 1, 64'h10, 64'h1122334455667788, 2, 2); set_req(0, 0);
        txn(1, 0, 64'h10, 64'h0, 2, 2);                set_req(1, 0);

        // Both ports held high: grants 0, 1, 0 with acks at +2, +5, +8.
        fork
            begin
                txn(0, 1, 64'h40, 64'hDEADBEEFCAFEF00D, 2, 2);
                txn(0, 0, 64'h40, 64'h0, 5, 5);
                set_req(0, 0);
            end
            begin
                txn(1, 1, 64'h48, 64'h0123456789ABCDEF, 5, 5);
                set_req(1, 0);
            end
        join

        // LED store from port 1.
        txn(1, 1, 64'h10000, 64'hA5, 2, 2); set_req(1, 0);

        // Out-of-range / unmapped accesses.
        txn(0, 0, 64'h30000, 64'h0, 2, 2);             set_req(0, 0);
        txn(0, 1, 64'd396, 64'h5555AAAA5555AAAA, 2, 2); set_req(0, 0);
        txn(0, 0, 64'h10, 64'h0, 2, 2);                set_req(0, 0);

        // req dropped (and bus scrambled) right after the grant.
        txn(0, 0, 64'h40, 64'h0, 2, 2, 1'b1);          set_req(0, 0);

        // Reset pulsed during SERVE of a store to 0x20.
        txn(0, 1, 64'h20, 64'h0BADF00D00C0FFEE, 2, 2); set_req(0, 0);
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 64'h20; bus.wdata0 = 64'hFFFF0000FFFF0000;
        @(posedge clk); #3;
        check("serve_mem_wr", 64'(bus.mem_wr), 1);
        rst = 1;
        #1;
        check_idle_outputs("midreset");
        bus.req0 = 0;
        @(posedge clk); #1;
        rst = 0;
        repeat (4) @(posedge clk);
        #1;
        txn(0, 0, 64'h20, 64'h0, 2, 2);                set_req(0, 0);

        // Random concurrent traffic on disjoint address sets.
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join

        repeat (6) @(posedge clk);
        #1;
        check("q0_drained", 64'(q0.size()), 0);
        check("q1_drained", 64'(q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
